// File: rtl/enigma_pkg.sv
// Shared types and wiring tables for the Enigma scrambler datapath.
// Tables are rotors I/II/III (forward and inverse) and reflector B, indexed by letter code.
package enigma_pkg;

   localparam int unsigned ALPHA = 26;

   typedef logic [4:0] letter_t;

   localparam letter_t    ALPHA_L = letter_t'(ALPHA);
   localparam logic [5:0] ALPHA6  = 6'(ALPHA);

   typedef enum logic [2:0] {
      StIdle, StStep, StWait, StFwd, StRefl, StBwd, StOut
   } state_e;

   typedef enum logic [1:0] {RotI, RotII, RotIII} rotor_e;

   localparam letter_t ROTOR_I_FWD [ALPHA] = '{
      5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
   localparam letter_t ROTOR_I_INV [ALPHA] = '{
      5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
   localparam letter_t ROTOR_II_FWD [ALPHA] = '{
      5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
   localparam letter_t ROTOR_II_INV [ALPHA] = '{
      5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
   localparam letter_t ROTOR_III_FWD [ALPHA] = '{
      5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
   localparam letter_t ROTOR_III_INV [ALPHA] = '{
      5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
   localparam letter_t REFLECTOR_B [ALPHA] = '{
      5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
      5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

   // Out-of-range stepper positions fold back into the alphabet once.
   function automatic letter_t wrap_pos(input letter_t p);
      return (p >= ALPHA_L) ? letter_t'(p - ALPHA_L) : p;
   endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// One rotor hop: c' = (W[(c+p) mod 26] - p) mod 26, with W the forward or inverse wiring.
module enigma_rotor_map
   import enigma_pkg::*;
(
   input  letter_t c_i,
   input  letter_t p_i,
   input  rotor_e  sel_i,
   input  logic    inv_i,
   output letter_t c_o
);

   logic [5:0] sum;
   logic [5:0] diff;
   letter_t    idx;
   letter_t    wired;

   always_comb begin
      sum   = {1'b0, c_i} + {1'b0, p_i};
      idx   = (sum >= ALPHA6) ? 5'(sum - ALPHA6) : sum[4:0];
      wired = '0;
      case (sel_i)
         RotI:    wired = inv_i ? ROTOR_I_INV[idx]   : ROTOR_I_FWD[idx];
         RotII:   wired = inv_i ? ROTOR_II_INV[idx]  : ROTOR_II_FWD[idx];
         RotIII:  wired = inv_i ? ROTOR_III_INV[idx] : ROTOR_III_FWD[idx];
         default: wired = '0;
      endcase
      // Bias by +26 so the subtraction never goes negative, then correct once.
      diff = {1'b0, wired} + ALPHA6 - {1'b0, p_i};
      c_o  = (diff >= ALPHA6) ? 5'(diff - ALPHA6) : diff[4:0];
   end

endmodule

// File: rtl/enigma_scrambler.sv
// Three-rotor Enigma scrambler: requests a rotor step per letter, then walks the letter
// through rotors, reflector and inverse rotors one hop per cycle using a shared rotor map.
module enigma_scrambler
   import enigma_pkg::*;
#(
   parameter int unsigned STEP_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] in_letter,
   input  logic [4:0] rotor1_pos,
   input  logic [4:0] rotor2_pos,
   input  logic [4:0] rotor3_pos,
   output logic       step_req,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] out_letter
);

   localparam logic [7:0] WaitLast = 8'(STEP_WAIT - 1);

   state_e     state_q;
   letter_t    c_q;
   letter_t    pos1_q, pos2_q, pos3_q;
   logic [1:0] hop_q;
   logic [7:0] wait_q;
   logic       in_ready_q, step_req_q, out_valid_q;
   letter_t    out_letter_q;

   logic       map_inv;
   logic [1:0] map_idx;
   rotor_e     map_sel;
   letter_t    map_pos;
   letter_t    map_out;

   // Forward walks rotor III, II, I; backward reverses the order with the same hop counter.
   always_comb begin
      map_inv = (state_q == StBwd);
      map_idx = map_inv ? 2'd2 - hop_q : hop_q;
      map_sel = RotIII;
      map_pos = pos1_q;
      case (map_idx)
         2'd0:    begin map_sel = RotIII; map_pos = pos1_q; end
         2'd1:    begin map_sel = RotII;  map_pos = pos2_q; end
         2'd2:    begin map_sel = RotI;   map_pos = pos3_q; end
         default: begin map_sel = RotIII; map_pos = pos1_q; end
      endcase
   end

   enigma_rotor_map u_rotor_map (
      .c_i   (c_q),
      .p_i   (map_pos),
      .sel_i (map_sel),
      .inv_i (map_inv),
      .c_o   (map_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         c_q          <= '0;
         pos1_q       <= '0;
         pos2_q       <= '0;
         pos3_q       <= '0;
         hop_q        <= '0;
         wait_q       <= '0;
         in_ready_q   <= 1'b1;
         step_req_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_letter_q <= '0;
      end else begin
         step_req_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  c_q        <= in_letter;
                  if (in_letter < ALPHA_L) begin
                     state_q    <= StStep;
                     step_req_q <= 1'b1;
                  end else begin
                     state_q      <= StOut;
                     out_valid_q  <= 1'b1;
                     out_letter_q <= in_letter;
                  end
               end
            end
            StStep: begin
               state_q <= StWait;
               wait_q  <= '0;
            end
            StWait: begin
               if (wait_q == WaitLast) begin
                  pos1_q  <= wrap_pos(rotor1_pos);
                  pos2_q  <= wrap_pos(rotor2_pos);
                  pos3_q  <= wrap_pos(rotor3_pos);
                  hop_q   <= '0;
                  state_q <= StFwd;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            StFwd: begin
               c_q <= map_out;
               if (hop_q == 2'd2) begin
                  hop_q   <= '0;
                  state_q <= StRefl;
               end else begin
                  hop_q <= hop_q + 2'd1;
               end
            end
            StRefl: begin
               c_q     <= REFLECTOR_B[c_q];
               state_q <= StBwd;
            end
            StBwd: begin
               c_q <= map_out;
               if (hop_q == 2'd2) begin
                  hop_q        <= '0;
                  out_valid_q  <= 1'b1;
                  out_letter_q <= map_out;
                  state_q      <= StOut;
               end else begin
                  hop_q <= hop_q + 2'd1;
               end
            end
            StOut: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign step_req   = step_req_q;
   assign out_valid  = out_valid_q;
   assign out_letter = out_letter_q;

endmodule

// File: tb/tb_enigma_scrambler.sv
// Directed bench for enigma_scrambler with a simple rotor1-only stepper model.
module tb_enigma_scrambler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [4:0] in_letter = '0;
   logic       in_ready, step_req, out_valid;
   logic [4:0] out_letter;
   logic [4:0] r1_base = '0, r2 = '0, r3 = '0;
   logic [4:0] rotor1_pos;

   int unsigned step_total = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Stepper model: rotor1 advances one cycle after each step_req pulse.
   always @(posedge clk) if (step_req) step_total <= step_total + 1;
   assign rotor1_pos = r1_base + step_total[4:0];

   enigma_scrambler #(.STEP_WAIT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_letter  (in_letter),
      .rotor1_pos (rotor1_pos),
      .rotor2_pos (r2),
      .rotor3_pos (r3),
      .step_req   (step_req),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_letter (out_letter)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pos(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
      r1_base = p1 - step_total[4:0];
      r2      = p2;
      r3      = p3;
   endtask

   // Leaves the bench in cycle 1 after the accepting edge.
   task automatic send_letter(input logic [4:0] l);
      in_valid  = 1'b1;
      in_letter = l;
      tick();
      in_valid  = 1'b0;
      in_letter = '0;
   endtask

   task automatic run_letter(input string tag, input logic [4:0] l, input logic [4:0] exp,
                             input int unsigned exp_steps);
      int unsigned s0;
      int          n;
      s0 = step_total;
      n  = 0;
      send_letter(l);
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check_eq({tag, " valid"}, out_valid, 1);
      check_eq(tag, out_letter, exp);
      check_eq({tag, " steps"}, step_total - s0, exp_steps);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int          bad;
      int unsigned s0;
      logic [4:0]  p0;
      logic [4:0]  plain [5];
      logic [4:0]  cipher [5];
      plain  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      cipher = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_eq("rst in_ready", in_ready, 1);
      check_eq("rst out_valid", out_valid, 0);
      check_eq("rst step_req", step_req, 0);
      check_eq("rst out_letter", out_letter, 0);

      // B at 0,0,0 steps to rotor1=1; reciprocal of A->B there, so B->A.
      set_pos(5'd0, 5'd0, 5'd0);
      s0 = step_total;
      send_letter(5'd1);
      check_eq("lat step_req c1", step_req, 1);
      bad = 0;
      for (int k = 1; k <= 9; k++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         tick();
      end
      check_eq("lat busy c1..9", bad, 0);
      check_eq("lat valid c10", out_valid, 1);
      check_eq("lat letter", out_letter, 0);
      check_eq("lat steps", step_total - s0, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // rotor1 now 1, steps to 2: B -> J.
      run_letter("B@2", 5'd1, 5'd9, 1);

      set_pos(5'd0, 5'd0, 5'd0);
      foreach (plain[i]) run_letter($sformatf("enc%0d", i), plain[i], cipher[i], 1);
      set_pos(5'd0, 5'd0, 5'd0);
      foreach (cipher[i]) run_letter($sformatf("dec%0d", i), cipher[i], plain[i], 1);

      // Middle and slow rotor offsets: positions 1,2,3 give A <-> E.
      set_pos(5'd0, 5'd2, 5'd3);
      run_letter("A@123", 5'd0, 5'd4, 1);
      set_pos(5'd0, 5'd2, 5'd3);
      run_letter("E@123", 5'd4, 5'd0, 1);

      // Passthrough code.
      s0 = step_total;
      p0 = rotor1_pos;
      send_letter(5'd26);
      check_eq("pass valid c1", out_valid, 1);
      check_eq("pass letter", out_letter, 26);
      check_eq("pass step_req", step_req, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("pass steps", step_total - s0, 0);
      check_eq("pass pos", rotor1_pos, p0);

      // Backpressure in OUT with a competing input.
      set_pos(5'd0, 5'd0, 5'd0);
      s0 = step_total;
      send_letter(5'd0);
      bad = 0;
      while (!out_valid && bad < 40) begin
         tick();
         bad++;
      end
      check_eq("bp reach out", out_valid, 1);
      in_valid  = 1'b1;
      in_letter = 5'd5;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid !== 1'b1 || out_letter !== 5'd1 || in_ready !== 1'b0) bad++;
         tick();
      end
      in_valid  = 1'b0;
      in_letter = '0;
      check_eq("bp stable", bad, 0);
      check_eq("bp refused", step_total - s0, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("bp idle in_ready", in_ready, 1);
      check_eq("bp idle out_valid", out_valid, 0);

      // Reset while in the forward hops.
      set_pos(5'd0, 5'd0, 5'd0);
      s0 = step_total;
      send_letter(5'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_eq("mid rst out_valid", out_valid, 0);
      check_eq("mid rst step_req", step_req, 0);
      rst = 1'b0;
      tick();
      check_eq("mid rst in_ready", in_ready, 1);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid !== 1'b0 || step_req !== 1'b0) bad++;
         tick();
      end
      check_eq("mid rst abandoned", bad, 0);
      check_eq("mid rst steps", step_total - s0, 1);
      set_pos(5'd0, 5'd0, 5'd0);
      run_letter("post rst", 5'd0, 5'd1, 1);

      // Position 27 folds to 1.
      set_pos(5'd26, 5'd0, 5'd0);
      run_letter("wrap enc", 5'd0, 5'd1, 1);
      set_pos(5'd26, 5'd0, 5'd0);
      run_letter("wrap dec", 5'd1, 5'd0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
